// File: rtl/bram_fifo_wr_arb.sv
// Round-robin arbiter that frames per-channel bursts (header + len words) onto
// a single FWFT BRAM FIFO write port, and counts FIFO write errors.

module bram_fifo_wr_arb_lane (
  input  logic       req,
  input  logic [7:0] len,
  input  logic       empty,
  input  logic       sel,
  input  logic       full,
  output logic       elig,
  output logic       rden
);
  assign elig = req && (len != 8'd0);
  assign rden = sel && !full && !empty;
endmodule

module bram_fifo_wr_arb #(
  parameter int N_CH = 4
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     CH_REQ,
  input  logic [8*N_CH-1:0]   CH_LEN,
  input  logic [32*N_CH-1:0]  CH_DI,
  input  logic [N_CH-1:0]     CH_EMPTY,
  output logic [N_CH-1:0]     CH_RDEN,
  output logic [N_CH-1:0]     GRANT,
  output logic                BUSY,
  output logic [31:0]         DO,
  output logic                WREN,
  input  logic                FULL,
  input  logic                WRERR,
  output logic [15:0]         ERR_CNT
);
  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t              state, state_nx;
  logic [GW-1:0]       g, last, pick;
  logic [7:0]          len, rem, g8;
  logic [15:0]         err_cnt;
  logic                hit;
  logic [N_CH-1:0]     elig, lane_sel;
  logic [N_CH-1:0][7:0]  len_a;
  logic [N_CH-1:0][31:0] di_a;

  assign len_a = CH_LEN;
  assign di_a  = CH_DI;
  assign g8    = 8'(g);

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_lane
      assign lane_sel[c] = (state == DATA) && (g == GW'(c));
      bram_fifo_wr_arb_lane u_lane (
        .req   (CH_REQ[c]),
        .len   (len_a[c]),
        .empty (CH_EMPTY[c]),
        .sel   (lane_sel[c]),
        .full  (FULL),
        .elig  (elig[c]),
        .rden  (CH_RDEN[c])
      );
    end
  endgenerate

  // First eligible channel strictly after the last winner, wrapping around.
  always_comb begin
    logic [GW-1:0] idx;
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = GW'((int'(last) + i) % N_CH);
      if (!hit && elig[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    DO       = '0;
    WREN     = 1'b0;
    case (state)
      IDLE: if (hit) state_nx = HDR;
      HDR: begin
        DO   = {8'hA5, g8, 8'h00, len};
        WREN = !FULL;
        if (!FULL) state_nx = DATA;
      end
      DATA: begin
        DO   = di_a[g];
        WREN = |CH_RDEN;
        if (WREN && rem == 8'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    GRANT = '0;
    if (state != IDLE) GRANT[g] = 1'b1;
  end

  assign BUSY    = (state != IDLE);
  assign ERR_CNT = err_cnt;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state   <= IDLE;
      g       <= '0;
      len     <= '0;
      rem     <= '0;
      last    <= GW'(N_CH - 1);
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (hit) begin
          g    <= pick;
          len  <= len_a[pick];
          rem  <= len_a[pick];
          last <= pick;
        end
        DATA: if (WREN) rem <= rem - 8'd1;
        default: ;
      endcase
      if (WRERR && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
endmodule

// File: doc/bram_fifo_wr_arb.md
# bram_fifo_wr_arb

Round-robin write-side arbiter that shares the single 32-bit FWFT BRAM FIFO write port between `N_CH` producer channels. Each channel's data comes from a local FWFT source FIFO. A granted burst is framed as one header word followed by exactly the requested number of data words. The block sits in the `CLK` domain, between the channel sources and the FIFO `DI`/`WREN`/`FULL` port. It also counts FIFO write errors.

## Interface
- `N_CH`, 4 — number of requesting channels, 1..16.
- `CLK`  in  1 — single clock; also drives the FIFO `WRCLK`.
- `reset_n`  in  1 — synchronous, active-low reset.
- `CH_REQ`  in  `N_CH` — per-channel burst request.
- `CH_LEN`  in  `8*N_CH` — per-channel burst length in words; channel c uses bits [8c+7:8c]; 0 = invalid.
- `CH_DI`  in  `32*N_CH` — per-channel source data (FWFT head word); channel c uses bits [32c+31:32c].
- `CH_EMPTY`  in  `N_CH` — per-channel source empty.
- `CH_RDEN`  out  `N_CH` — per-channel source read enable (pop).
- `GRANT`  out  `N_CH` — one-hot registered grant; 0 when idle.
- `BUSY`  out  1 — high in the HDR and DATA states.
- `DO`  out  32 — to FIFO `DI`.
- `WREN`  out  1 — to FIFO `WREN`.
- `FULL`  in  1 — from FIFO `FULL`.
- `WRERR`  in  1 — from FIFO `WRERR`.
- `ERR_CNT`  out  16 — saturating count of cycles with `WRERR`=1.

## Operation
- State machine: IDLE, HDR, DATA.
- Registered state: state, grant index `g`, latched length `len`, remaining count `rem` (8 bit), round-robin pointer `last`, `ERR_CNT`.

**IDLE**
- Eligible set: `CH_REQ[c] && CH_LEN[c]!=0`.
- Search starts at `(last+1) mod N_CH` and picks the first eligible channel.
- On a hit: latch `g`, `len=CH_LEN[g]`, `rem=len`, `last=g`; go to HDR.
- `WREN`=0, `CH_RDEN`=0, `DO`=0.

**HDR**
- `DO={8'hA5, 8'(g), 8'h00, len}`.
- `WREN=!FULL`.
- If `!FULL`, go to DATA.

**DATA**
- `DO=CH_DI[g]`.
- `WREN = CH_RDEN[g] = !FULL && !CH_EMPTY[g]`; all other `CH_RDEN` bits are 0.
- Each write decrements `rem`.
- A write with `rem==1` goes to IDLE.

**General rules**
- `DO`, `WREN` and `CH_RDEN` are combinational from registered state, `FULL` and `CH_EMPTY`.
- `WREN` is never asserted while `FULL`=1, so the FIFO write-buffer path is never exercised by this block.
- `GRANT` is one-hot of `g` in HDR and DATA, and 0 in IDLE. `BUSY` is 1 in HDR and DATA.
- `CH_REQ` and `CH_LEN` are sampled only in IDLE. A requester may drop `CH_REQ` once `GRANT` is set; later changes do not affect the burst in progress.
- There is no timeout. A granted source that stays empty holds the arbiter in DATA indefinitely. Producers guarantee `len` words.
- `ERR_CNT` increments on `WRERR`=1 in any state and saturates at 16'hFFFF.

**Reset** (`reset_n`=0 at a rising edge)
- state=IDLE, `last=N_CH-1` (so channel 0 has first priority), `rem`=0, `GRANT`=0, `ERR_CNT`=0.
- Outputs settle to `WREN`=0, `CH_RDEN`=0, `DO`=0, `BUSY`=0.
- A reset mid-burst abandons the burst. Resetting the FIFO is the integrator's job.

## Timing
- Request visible at edge k in IDLE → HDR from k+1. With `FULL`=0, the header is written at edge k+1 and the first data word at edge k+2.
- Burst of L words with no stalls: L+1 write cycles, plus 1 IDLE arbitration cycle before the next header.
- Peak throughput is `len/(len+2)`.
- `FULL` or `CH_EMPTY` stalls add 1 cycle each; `DO` stays stable while stalled.
- The header is never popped from a source; exactly `len` source words are popped per burst.
- Round-robin fairness: with all channels requesting continuously, grants cycle 0,1,…,N_CH-1,0.

## Test plan
- **Single burst:** ch0 REQ, LEN=3, data 0x11,0x22,0x33, FULL=0 → FIFO receives 0xA5000003, 0x11, 0x22, 0x33 on 4 consecutive edges; GRANT=0001 during the burst; back to IDLE.
- **Round robin:** ch1 and ch2 request continuously, LEN=2 each, after reset → burst order ch1, ch2, ch1; headers 0xA5010002, then 0xA5020002.
- **FULL backpressure:** FULL=1 for 5 cycles mid-DATA of a LEN=4 burst → WREN=0 and CH_RDEN=0 during the stall, DO held; still exactly 5 words written in order.
- **Source underrun:** CH_EMPTY[0]=1 for 3 cycles after the header → no write and no pop during those cycles; the burst resumes and completes with the correct count.
- **Reset mid-burst:** reset_n=0 with rem=2 → the next cycle shows GRANT=0, BUSY=0, WREN=0; ch0 wins first after release.
- **Zero length and errors:** LEN=0 with REQ=1 → never granted. WRERR pulsed 3 times → ERR_CNT=3. Forced to 0xFFFF plus one more WRERR → stays 0xFFFF.
